reg_bank: RTL and testbench

Parametrised multi-word register bank, successor to the single-word init/write register in the RSSB datapath. Holds DEPTH words of WIDTH bits with one write port and two independent registered read ports, so the core can fetch an operand and the accumulator in the same cycle. After reset, a sweep state machine loads a common init value into every word before the bank accepts traffic.

---
 rtl/reg_bank_pkg.sv | 12 +
 rtl/reg_bank_init_ctrl.sv | 66 ++++++
 rtl/reg_bank.sv | 101 ++++++++++
 tb/tb_reg_bank.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the multi-word register bank.
// Imported by the bank top and its init sweep controller.
package reg_bank_pkg;

    typedef enum logic {INIT, RUN} reg_bank_state_t;

    // True when an address falls inside a bank of the given depth.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_bank_init_ctrl.sv
// Post-reset sweep controller: walks every word once with the captured init value,
// then raises ready and stays in RUN until the next reset.
module reg_bank_init_ctrl
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  init_val,
    output logic              ready,
    output logic              sweep_we_c,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic [WIDTH-1:0]  sweep_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    reg_bank_state_t   state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  init_q;
    logic              ready_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
            init_q  <= init_val;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready   <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ready_d    = ready;
        sweep_we_c = 1'b0;
        case (state_q)
            INIT: begin
                sweep_we_c = !rst;
                ptr_d      = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_ADDR) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                    ptr_d   = '0;
                end
            end
            RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign sweep_addr = ptr_q;
    assign sweep_data = init_q;

endmodule

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register bank with one write port and two registered read ports,
// filled with a common init value by a post-reset sweep before traffic is accepted.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  init_val,
    output logic              ready,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              rvalid_a,
    output logic              rvalid_b
);

    logic [WIDTH-1:0]  word [DEPTH];

    logic              sweep_we_c;
    logic [ADDR_W-1:0] sweep_addr;
    logic [WIDTH-1:0]  sweep_data;

    logic              user_we_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [WIDTH-1:0]  wr_data_c;
    logic [WIDTH-1:0]  rd_a_c;
    logic [WIDTH-1:0]  rd_b_c;

    reg_bank_init_ctrl #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_ctrl (
        .clk        (clk),
        .rst        (rst),
        .init_val   (init_val),
        .ready      (ready),
        .sweep_we_c (sweep_we_c),
        .sweep_addr (sweep_addr),
        .sweep_data (sweep_data)
    );

    // Sweep owns the write port until ready; out-of-range user writes are dropped.
    always_comb begin
        user_we_c = ready && we && addr_in_range(32'(waddr), DEPTH);
        wr_en_c   = sweep_we_c || user_we_c;
        wr_addr_c = sweep_we_c ? sweep_addr : waddr;
        wr_data_c = sweep_we_c ? sweep_data : wdata;
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            word[wr_addr_c] <= wr_data_c;
        end
    end

    // Read muxes with write-first bypass; out-of-range reads return zero.
    always_comb begin
        rd_a_c = '0;
        if (addr_in_range(32'(raddr_a), DEPTH)) begin
            rd_a_c = (user_we_c && (waddr == raddr_a)) ? wdata : word[raddr_a];
        end
    end

    always_comb begin
        rd_b_c = '0;
        if (addr_in_range(32'(raddr_b), DEPTH)) begin
            rd_b_c = (user_we_c && (waddr == raddr_b)) ? wdata : word[raddr_b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a  <= '0;
            rdata_b  <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= ready && re_a;
            rvalid_b <= ready && re_b;
            if (ready && re_a) begin
                rdata_a <= rd_a_c;
            end
            if (ready && re_b) begin
                rdata_b <= rd_b_c;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: a DEPTH=16 and a DEPTH=10 instance share all inputs,
// each tracked by its own reference memory and per-port expected-read queues.
module tb_reg_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] init_val;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       re_a, re_b;
    logic [3:0] raddr_a, raddr_b;

    logic       ready16, rvalid_a16, rvalid_b16;
    logic [7:0] rdata_a16, rdata_b16;
    logic       ready10, rvalid_a10, rvalid_b10;
    logic [7:0] rdata_a10, rdata_b10;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m16 [16];
    logic [7:0] m10 [10];
    logic [7:0] qa16[$], qb16[$], qa10[$], qb10[$];
    logic       ev_a16 = 1'b0, ev_b16 = 1'b0, ev_a10 = 1'b0, ev_b10 = 1'b0;

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(8), .DEPTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .init_val(init_val), .ready(ready16),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
        .rdata_a(rdata_a16), .rdata_b(rdata_b16),
        .rvalid_a(rvalid_a16), .rvalid_b(rvalid_b16)
    );

    reg_bank #(.WIDTH(8), .DEPTH(10)) u_dut10 (
        .clk(clk), .rst(rst), .init_val(init_val), .ready(ready10),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
        .rdata_a(rdata_a10), .rdata_b(rdata_b10),
        .rvalid_a(rvalid_a10), .rvalid_b(rvalid_b10)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp16(input logic [3:0] a, input logic w,
                                         input logic [3:0] wa, input logic [7:0] wd);
        if (w && wa == a) return wd;
        return m16[a];
    endfunction

    function automatic logic [7:0] exp10(input logic [3:0] a, input logic w,
                                         input logic [3:0] wa, input logic [7:0] wd);
        if (a >= 4'd10) return 8'h00;
        if (w && wa == a) return wd;
        return m10[a];
    endfunction

    // Drive one cycle of traffic (called just after a falling edge), record expectations.
    task automatic cycle(input logic twe, input logic [3:0] twa, input logic [7:0] twd,
                         input logic tra, input logic [3:0] taa,
                         input logic trb, input logic [3:0] tab);
        logic live16, live10;
        we = twe; waddr = twa; wdata = twd;
        re_a = tra; raddr_a = taa; re_b = trb; raddr_b = tab;
        live16 = !rst && ready16;
        live10 = !rst && ready10;
        ev_a16 = live16 && tra;
        ev_b16 = live16 && trb;
        ev_a10 = live10 && tra;
        ev_b10 = live10 && trb;
        if (ev_a16) qa16.push_back(exp16(taa, twe, twa, twd));
        if (ev_b16) qb16.push_back(exp16(tab, twe, twa, twd));
        if (ev_a10) qa10.push_back(exp10(taa, twe, twa, twd));
        if (ev_b10) qb10.push_back(exp10(tab, twe, twa, twd));
        if (live16 && twe) m16[twa] = twd;
        if (live10 && twe && twa < 4'd10) m10[twa] = twd;
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic rand_cycle();
        logic [3:0] wa;
        wa = 4'($urandom_range(0, 15));
        cycle(1'($urandom_range(0, 1)), wa, 8'($urandom),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    endtask

    task automatic fill_model(input logic [7:0] v);
        for (int i = 0; i < 16; i++) m16[i] = v;
        for (int i = 0; i < 10; i++) m10[i] = v;
    endtask

    // Count cycles from the first non-reset cycle until each instance reports ready.
    task automatic sweep_and_count(input logic traffic);
        int c16 = -1;
        int c10 = -1;
        for (int n = 0; n < 64; n++) begin
            if (ready16 && c16 < 0) c16 = n;
            if (ready10 && c10 < 0) c10 = n;
            if (c16 >= 0 && c10 >= 0) break;
            if (traffic && !ready10) rand_cycle();
            else idle();
        end
        check("sweep_len16", 32'(c16), 32'd16);
        check("sweep_len10", 32'(c10), 32'd10);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'(i), 1'b1, 4'(15 - i));
        end
        idle();
    endtask

    // Monitor: sample one unit after each rising edge, compare against the scoreboard.
    always @(posedge clk) begin
        #1;
        check("rvalid_a16", 32'(rvalid_a16), 32'(ev_a16));
        check("rvalid_b16", 32'(rvalid_b16), 32'(ev_b16));
        check("rvalid_a10", 32'(rvalid_a10), 32'(ev_a10));
        check("rvalid_b10", 32'(rvalid_b10), 32'(ev_b10));
        if (rvalid_a16 === 1'b1 && qa16.size() > 0) check("rdata_a16", 32'(rdata_a16), 32'(qa16.pop_front()));
        if (rvalid_b16 === 1'b1 && qb16.size() > 0) check("rdata_b16", 32'(rdata_b16), 32'(qb16.pop_front()));
        if (rvalid_a10 === 1'b1 && qa10.size() > 0) check("rdata_a10", 32'(rdata_a10), 32'(qa10.pop_front()));
        if (rvalid_b10 === 1'b1 && qb10.size() > 0) check("rdata_b10", 32'(rdata_b10), 32'(qb10.pop_front()));
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        init_val = 8'hA5;
        we = 1'b0; waddr = '0; wdata = '0;
        re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
        @(negedge clk);
        idle();
        idle();

        check("reset_ready16", 32'(ready16), 32'd0);
        check("reset_ready10", 32'(ready10), 32'd0);
        check("reset_rdata_a16", 32'(rdata_a16), 32'd0);
        check("reset_rdata_b16", 32'(rdata_b16), 32'd0);
        check("reset_rdata_a10", 32'(rdata_a10), 32'd0);
        check("reset_rdata_b10", 32'(rdata_b10), 32'd0);

        // Plain sweep with A5, then read every address on both ports.
        rst = 1'b0;
        fill_model(8'hA5);
        sweep_and_count(1'b0);
        read_all();

        // Write then read next cycle.
        cycle(1'b1, 4'd5, 8'h3C, 1'b0, 4'd0, 1'b0, 4'd0);
        cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b1, 4'd4);
        idle();

        // Same-cycle write and read on both ports.
        cycle(1'b1, 4'd7, 8'h11, 1'b1, 4'd7, 1'b1, 4'd7);
        idle();

        // Address 12 is out of range for the DEPTH=10 instance only.
        cycle(1'b1, 4'd12, 8'h77, 1'b0, 4'd0, 1'b0, 4'd0);
        cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd12, 1'b1, 4'd9);
        idle();

        for (int i = 0; i < 200; i++) rand_cycle();
        idle();

        // Reset mid-sweep with a new init value; traffic during the sweep must be ignored.
        rst = 1'b1;
        init_val = 8'h00;
        idle();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) rand_cycle();
        rst = 1'b1;
        init_val = 8'hFF;
        idle();
        rst = 1'b0;
        init_val = 8'h5A;
        fill_model(8'hFF);
        sweep_and_count(1'b1);
        read_all();
        idle();
        idle();

        check("pending_a16", 32'(qa16.size()), 32'd0);
        check("pending_b16", 32'(qb16.size()), 32'd0);
        check("pending_a10", 32'(qa10.size()), 32'd0);
        check("pending_b10", 32'(qb10.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
